// File: rtl/combo_lock_fsm.sv
// Combination-lock controller: collects keypad digits, opens on a full correct
// code, counts consecutive failed attempts and enters a timed lockout after
// MAX_TRIES of them. Optional auto-relock after OPEN_CYCLES clocks in OPEN.
module combo_lock_fsm #(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned OPEN_CYCLES    = 0,
  localparam int unsigned DeW           = $clog2(CODE_LEN + 1),
  localparam int unsigned FcW           = $clog2(MAX_TRIES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               clear,
  input  logic               relock,
  output logic               unlocked,
  output logic               locked_out,
  output logic               fail_pulse,
  output logic [DeW-1:0]     digits_entered,
  output logic [FcW-1:0]     fail_count
);

  localparam logic [1:0] StLocked  = 2'd0;
  localparam logic [1:0] StOpen    = 2'd1;
  localparam logic [1:0] StLockout = 2'd2;

  localparam int unsigned LcW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned OcW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  logic [1:0]         state_q, state_d;
  logic [DeW-1:0]     cnt_q, cnt_d;
  logic [FcW-1:0]     fails_q, fails_d;
  logic               mismatch_q, mismatch_d;
  logic               fail_pulse_q, fail_pulse_d;
  logic               unlocked_q, locked_out_q;
  logic [LcW-1:0]     lock_tmr_q, lock_tmr_d;
  logic [OcW-1:0]     open_tmr_q, open_tmr_d;
  logic [DIGIT_W-1:0] exp_digit;
  logic               any_mismatch;
  logic               last_digit;

  // Select the code digit expected at the current entry position (MS digit first).
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      if (cnt_q == DeW'(i)) begin
        exp_digit = CODE[(int'(CODE_LEN) - 1 - i) * int'(DIGIT_W) +: DIGIT_W];
      end
    end
  end

  // Sticky mismatch including the digit being accepted this cycle.
  always_comb begin
    any_mismatch = mismatch_q | (digit != exp_digit);
    last_digit   = (cnt_q == DeW'(CODE_LEN - 1));
  end

  // Next-state, counter and timer logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fails_d      = fails_q;
    mismatch_d   = mismatch_q;
    fail_pulse_d = 1'b0;
    lock_tmr_d   = lock_tmr_q;
    open_tmr_d   = open_tmr_q;
    case (state_q)
      StLocked: begin
        // clear takes priority and discards a simultaneous digit
        if (clear) begin
          cnt_d      = '0;
          mismatch_d = 1'b0;
        end else if (digit_valid) begin
          if (last_digit) begin
            cnt_d      = '0;
            mismatch_d = 1'b0;
            if (!any_mismatch) begin
              state_d    = StOpen;
              fails_d    = '0;
              open_tmr_d = OcW'(OPEN_CYCLES - 1);
            end else begin
              fail_pulse_d = 1'b1;
              fails_d      = fails_q + FcW'(1);
              if (fails_q == FcW'(MAX_TRIES - 1)) begin
                state_d    = StLockout;
                lock_tmr_d = LcW'(LOCKOUT_CYCLES - 1);
              end
            end
          end else begin
            cnt_d      = cnt_q + DeW'(1);
            mismatch_d = any_mismatch;
          end
        end
      end
      StOpen: begin
        // relock and timer expiry together still make one transition
        if (relock) begin
          state_d = StLocked;
          fails_d = '0;
        end else if (OPEN_CYCLES > 0) begin
          if (open_tmr_q == '0) begin
            state_d = StLocked;
          end else begin
            open_tmr_d = open_tmr_q - OcW'(1);
          end
        end
      end
      StLockout: begin
        if (lock_tmr_q == '0) begin
          state_d    = StLocked;
          fails_d    = '0;
          cnt_d      = '0;
          mismatch_d = 1'b0;
        end else begin
          lock_tmr_d = lock_tmr_q - LcW'(1);
        end
      end
      default: begin
        state_d = StLocked;
      end
    endcase
  end

  // State and registered outputs, asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StLocked;
      cnt_q        <= '0;
      fails_q      <= '0;
      mismatch_q   <= 1'b0;
      fail_pulse_q <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      lock_tmr_q   <= '0;
      open_tmr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fails_q      <= fails_d;
      mismatch_q   <= mismatch_d;
      fail_pulse_q <= fail_pulse_d;
      unlocked_q   <= (state_d == StOpen);
      locked_out_q <= (state_d == StLockout);
      lock_tmr_q   <= lock_tmr_d;
      open_tmr_q   <= open_tmr_d;
    end
  end

  assign unlocked       = unlocked_q;
  assign locked_out     = locked_out_q;
  assign fail_pulse     = fail_pulse_q;
  assign digits_entered = cnt_q;
  assign fail_count     = fails_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Bench for combo_lock_fsm: two instances (default params, and a short
// lockout / auto-relock variant) share stimulus and are compared every cycle
// against an attempt-level reference model.
module tb_combo_lock_fsm;

  logic       clk;
  logic       rst;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic       relock;

  logic       unl [2];
  logic       lko [2];
  logic       fpl [2];
  logic [2:0] den [2];
  logic [1:0] fcn [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, per instance.
  int m_n         [2];
  int m_d         [2][4];
  bit m_open      [2];
  int m_open_left [2];
  int m_lock_left [2];
  int m_fails     [2];
  bit m_pulse     [2];

  combo_lock_fsm u_dut0 (
    .clk           (clk),
    .rst           (rst),
    .digit_valid   (digit_valid),
    .digit         (digit),
    .clear         (clear),
    .relock        (relock),
    .unlocked      (unl[0]),
    .locked_out    (lko[0]),
    .fail_pulse    (fpl[0]),
    .digits_entered(den[0]),
    .fail_count    (fcn[0])
  );

  combo_lock_fsm #(
    .MAX_TRIES     (2),
    .LOCKOUT_CYCLES(3),
    .OPEN_CYCLES   (5)
  ) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .digit_valid   (digit_valid),
    .digit         (digit),
    .clear         (clear),
    .relock        (relock),
    .unlocked      (unl[1]),
    .locked_out    (lko[1]),
    .fail_pulse    (fpl[1]),
    .digits_entered(den[1]),
    .fail_count    (fcn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int max_tries(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  function automatic int lock_cyc(input int k);
    return (k == 0) ? 16 : 3;
  endfunction

  function automatic int open_cyc(input int k);
    return (k == 0) ? 0 : 5;
  endfunction

  function automatic int code_dig(input int i);
    logic [15:0] c;
    c = 16'h1234;
    return int'(c[4*(3-i) +: 4]);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset(input int k);
    m_n[k]         = 0;
    m_open[k]      = 1'b0;
    m_open_left[k] = 0;
    m_lock_left[k] = 0;
    m_fails[k]     = 0;
    m_pulse[k]     = 1'b0;
  endfunction

  // One clock of behaviour at the attempt level.
  function automatic void model_step(input int k, input bit dv, input int d, input bit clr,
                                     input bit rl);
    bit ok;
    m_pulse[k] = 1'b0;
    if (m_lock_left[k] > 0) begin
      m_lock_left[k]--;
      if (m_lock_left[k] == 0) begin
        m_fails[k] = 0;
        m_n[k]     = 0;
      end
    end else if (m_open[k]) begin
      if (rl) begin
        m_open[k]  = 1'b0;
        m_fails[k] = 0;
      end else if (open_cyc(k) > 0) begin
        m_open_left[k]--;
        if (m_open_left[k] == 0) m_open[k] = 1'b0;
      end
    end else if (clr) begin
      m_n[k] = 0;
    end else if (dv) begin
      m_d[k][m_n[k]] = d;
      m_n[k]++;
      if (m_n[k] == 4) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (m_d[k][i] != code_dig(i)) ok = 1'b0;
        m_n[k] = 0;
        if (ok) begin
          m_open[k]      = 1'b1;
          m_open_left[k] = open_cyc(k);
          m_fails[k]     = 0;
        end else begin
          m_pulse[k] = 1'b1;
          m_fails[k]++;
          if (m_fails[k] == max_tries(k)) m_lock_left[k] = lock_cyc(k);
        end
      end
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("dut%0d unlocked", k), 32'(unl[k]), 32'(m_open[k]));
      check_eq($sformatf("dut%0d locked_out", k), 32'(lko[k]), 32'(m_lock_left[k] > 0));
      check_eq($sformatf("dut%0d fail_pulse", k), 32'(fpl[k]), 32'(m_pulse[k]));
      check_eq($sformatf("dut%0d digits_entered", k), 32'(den[k]), m_n[k]);
      check_eq($sformatf("dut%0d fail_count", k), 32'(fcn[k]), m_fails[k]);
    end
  endtask

  task automatic cycle(input bit dv, input int d, input bit clr, input bit rl);
    @(negedge clk);
    digit_valid = dv;
    digit       = 4'(d);
    clear       = clr;
    relock      = rl;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_step(k, dv, d, clr, rl);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic enter(input int a, input int b, input int c, input int d);
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b0, 1'b0);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  // Reset lands mid-cycle, so outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) model_reset(k);
    compare_all();
    @(negedge clk);
    rst         = 1'b0;
    digit_valid = 1'b0;
    clear       = 1'b0;
    relock      = 1'b0;
  endtask

  initial begin
    bit dv, clr, rl;
    int d;
    rst         = 1'b1;
    digit_valid = 1'b0;
    digit       = '0;
    clear       = 1'b0;
    relock      = 1'b0;
    #3;
    for (int k = 0; k < 2; k++) model_reset(k);
    compare_all();
    do_reset();

    // Correct code, then relock.
    enter(1, 2, 3, 4);
    idle(2);
    cycle(1'b0, 0, 1'b0, 1'b1);
    idle(2);

    // One wrong attempt, then correct.
    enter(1, 2, 9, 4);
    enter(1, 2, 3, 4);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Three failures -> lockout; digits ignored during it.
    enter(0, 0, 0, 0);
    enter(0, 0, 0, 0);
    enter(0, 0, 0, 0);
    enter(1, 2, 3, 4);
    idle(14);
    enter(1, 2, 3, 4);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Clear mid-entry; clear wins over a simultaneous digit.
    enter(0, 0, 0, 0);
    cycle(1'b1, 1, 1'b0, 1'b0);
    cycle(1'b1, 2, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 3, 1'b1, 1'b0);
    idle(2);

    // Auto-relock, and relock coinciding with expiry.
    enter(1, 2, 3, 4);
    idle(8);
    enter(1, 2, 3, 4);
    idle(4);
    cycle(1'b0, 0, 1'b0, 1'b1);
    idle(2);

    // Reset mid-lockout and mid-entry.
    enter(0, 0, 0, 0);
    enter(0, 0, 0, 0);
    enter(0, 0, 0, 0);
    idle(7);
    do_reset();
    cycle(1'b1, 1, 1'b0, 1'b0);
    cycle(1'b1, 2, 1'b0, 1'b0);
    cycle(1'b1, 3, 1'b0, 1'b0);
    do_reset();
    enter(1, 2, 3, 4);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Random traffic biased toward the correct next digit.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        dv  = ($urandom_range(0, 9) < 6);
        d   = ($urandom_range(0, 3) != 0) ? code_dig(m_n[0]) : int'($urandom_range(0, 15));
        clr = ($urandom_range(0, 39) == 0);
        rl  = ($urandom_range(0, 11) == 0);
        cycle(dv, d, clr, rl);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
